reg_16bit: RTL and testbench

// - General-purpose 16-bit load-enabled storage register; the basic holding

---
 rtl/reg_16bit.sv | 58 +++++
 tb/tb_reg_16bit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/reg_16bit.sv
// Load-enabled storage register with synchronous active-high reset (rst > ld > hold).
// Optional even-parity flop q_par is enabled by defining REG_16BIT_PARITY_EN.
module reg_16bit #(
  parameter int unsigned     WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
`ifdef REG_16BIT_PARITY_EN
  output logic             q_par,
`endif
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Next-state select: reset wins over load, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (rst) begin
      q_d = RST_VAL;
    end else if (ld) begin
      q_d = d;
    end
  end

  // No power-up initialiser: q is undefined until the first reset or load.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

`ifdef REG_16BIT_PARITY_EN
  logic par_d;
  logic par_q;

  // Parity tracks q under the same priority, so q_par == ^q once defined.
  always_comb begin
    par_d = par_q;
    if (rst) begin
      par_d = ^RST_VAL;
    end else if (ld) begin
      par_d = ^d;
    end
  end

  always_ff @(posedge clk) begin
    par_q <= par_d;
  end

  assign q_par = par_q;
`endif

endmodule

// File: tb/tb_reg_16bit.sv
// Self-checking bench for reg_16bit: per-cycle model compare plus directed literal checks.
// Parity checks are included when REG_16BIT_PARITY_EN is defined.
module tb_reg_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld  = 1'b0;
  logic [15:0] d   = 16'h0000;
  logic [15:0] q;
`ifdef REG_16BIT_PARITY_EN
  logic        q_par;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Behavioural model: last value q must hold, valid after first reset/load.
  logic [15:0] model_q = 16'h0000;
  bit          model_valid = 1'b0;

  reg_16bit #(
    .WIDTH  (16),
    .RST_VAL(16'h0000)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld),
    .d    (d),
`ifdef REG_16BIT_PARITY_EN
    .q_par(q_par),
`endif
    .q    (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Model update: what a register with rst > ld > hold must hold after this edge.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      model_q     = 16'h0000;
      model_valid = 1'b1;
    end else if (ld === 1'b1) begin
      model_q     = d;
      model_valid = 1'b1;
    end
  end

  // Per-cycle compare, sampled on the falling edge away from updates.
  always @(negedge clk) begin
    if (model_valid) begin
      check("model_q", q, model_q);
`ifdef REG_16BIT_PARITY_EN
      check("model_par", 16'(q_par), 16'(^model_q));
`endif
    end
  end

  // Apply one set of inputs mid-cycle, then return just after the following rising edge.
  task automatic step(input logic r, input logic l, input logic [15:0] v);
    @(negedge clk);
    #1;
    rst = r;
    ld  = l;
    d   = v;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] vec [0:5];
  logic        vld [0:5];

  initial begin
    vec[0] = 16'hFFFF; vld[0] = 1'b1;
    vec[1] = 16'h8000; vld[1] = 1'b1;
    vec[2] = 16'h0001; vld[2] = 1'b0;
    vec[3] = 16'h7FFE; vld[3] = 1'b1;
    vec[4] = 16'h7FFE; vld[4] = 1'b1;
    vec[5] = 16'hC3C3; vld[5] = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 16'h0000);
    check("reset_q", q, 16'h0000);

    // Load sequence
    step(1'b0, 1'b1, 16'h0011);
    check("load1", q, 16'h0011);
    step(1'b0, 1'b1, 16'h1110);
    check("load2", q, 16'h1110);
    step(1'b0, 1'b1, 16'h1100);
    check("load3", q, 16'h1100);

    // Reset overrides simultaneous load
    step(1'b1, 1'b1, 16'h0010);
    check("rst_over_ld", q, 16'h0000);

    // Hold with ld=0 while d toggles to all ones
    step(1'b0, 1'b1, 16'hA5A5);
    check("hold_load", q, 16'hA5A5);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 16'hFFFF);
      check("hold", q, 16'hA5A5);
    end

    // Mid-cycle d change: q only moves on the next rising edge
    step(1'b0, 1'b1, 16'h1234);
    check("mid_load", q, 16'h1234);
    #1;
    d = 16'h5678;
    #1;
    check("no_comb_path", q, 16'h1234);
    @(posedge clk);
    #1;
    check("mid_next_edge", q, 16'h5678);

    // rst pulse between edges has no effect
    ld = 1'b0;
    #1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("rst_glitch_now", q, 16'h5678);
    @(posedge clk);
    #1;
    check("rst_glitch_edge", q, 16'h5678);

    // Mixed directed vectors; the per-cycle model compare covers these
    for (int i = 0; i < 6; i++) begin
      step(1'b0, vld[i], vec[i]);
    end
    check("vec_final", q, 16'h7FFE);

`ifdef REG_16BIT_PARITY_EN
    step(1'b0, 1'b1, 16'h0001);
    check("par_0001", 16'(q_par), 16'h0001);
    step(1'b0, 1'b1, 16'h0003);
    check("par_0003", 16'(q_par), 16'h0000);
    step(1'b0, 1'b1, 16'h0001);
    step(1'b1, 1'b0, 16'h0000);
    check("par_reset", 16'(q_par), 16'h0000);
`endif

    step(1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish, got %0d passes, expected completion", pass_cnt);
    $fatal(1, "timeout");
  end

endmodule
